// File: rtl/ldpc_codeword_serializer_if.sv
// Handshake bundle between the LDPC encoder, the codeword serializer and the
// downstream modulator/FIFO.
interface ldpc_codeword_serializer_if #(
  parameter int unsigned Z          = 54,
  parameter int unsigned TOTAL_BLKS = 24,
  parameter int unsigned OUT_W      = 8
);
  logic [Z-1:0]     in_codeword [TOTAL_BLKS];
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             busy;

  // Encoder plus downstream sink side.
  modport master (
    output in_codeword, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy
  );

  // Serializer side.
  modport slave (
    input  in_codeword, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/ldpc_codeword_serializer.sv
// Captures a full parallel QC-LDPC codeword and streams it out as OUT_W-bit beats,
// block 0 first, LSB first, with back-to-back frames and no bubble.
module ldpc_codeword_serializer #(
  parameter int unsigned Z          = 54,
  parameter int unsigned TOTAL_BLKS = 24,
  parameter int unsigned OUT_W      = 8
) (
  input  logic                         CLK,
  input  logic                         rst,
  ldpc_codeword_serializer_if.slave    bus
);

  localparam int unsigned FlatW     = Z * TOTAL_BLKS;
  localparam int unsigned NUM_BEATS = FlatW / OUT_W;
  localparam int unsigned CntW      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_BEATS - 1);

  if ((FlatW % OUT_W) != 0) begin : gen_bad_width
    $error("Z*TOTAL_BLKS must be a multiple of OUT_W");
  end

  typedef enum logic {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [FlatW-1:0] frame_q;
  logic [FlatW-1:0] flat_in;
  logic             send, last_beat, beat_acc, accept;

  always_comb begin
    flat_in = '0;
    for (int k = 0; k < TOTAL_BLKS; k++) begin
      flat_in[k*Z +: Z] = bus.in_codeword[k];
    end
  end

  assign send      = (state_q == StSend);
  assign last_beat = (cnt_q == LastCnt);
  assign beat_acc  = send && bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame buffer content is don't-care after reset, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      frame_q <= flat_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StSend;
      StSend: if (beat_acc && last_beat && !accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (accept) begin
      cnt_d = '0;
    end else if (beat_acc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // in_ready only looks at state and out_ready, never at in_valid.
  always_comb begin
    bus.out_valid = send;
    bus.busy      = send;
    bus.out_last  = send && last_beat;
    bus.out_data  = send ? frame_q[int'(cnt_q)*OUT_W +: OUT_W] : '0;
    bus.in_ready  = !rst && (!send || (beat_acc && last_beat));
  end

endmodule

// File: tb/tb_ldpc_codeword_serializer.sv
// Scoreboard bench for ldpc_codeword_serializer: directed frames, back-to-back,
// backpressure, mid-frame reset, input-ignore and a Z=27/81 sweep.
module tb_ldpc_codeword_serializer;

  localparam int unsigned Z      = 54;
  localparam int unsigned NB     = 24;
  localparam int unsigned W      = 8;
  localparam int unsigned NBEATS = 162;
  localparam int unsigned FLAT   = Z * NB;

  typedef logic [Z-1:0]  cw_t   [NB];
  typedef logic [26:0]   cw27_t [NB];
  typedef logic [80:0]   cw81_t [NB];

  logic CLK = 1'b0;
  logic rst = 1'b0;

  ldpc_codeword_serializer_if #(.Z(Z),  .TOTAL_BLKS(NB), .OUT_W(W)) bus   ();
  ldpc_codeword_serializer_if #(.Z(27), .TOTAL_BLKS(NB), .OUT_W(W)) bus27 ();
  ldpc_codeword_serializer_if #(.Z(81), .TOTAL_BLKS(NB), .OUT_W(W)) bus81 ();

  ldpc_codeword_serializer #(.Z(Z),  .TOTAL_BLKS(NB), .OUT_W(W)) dut   (.CLK(CLK), .rst(rst), .bus(bus));
  ldpc_codeword_serializer #(.Z(27), .TOTAL_BLKS(NB), .OUT_W(W)) dut27 (.CLK(CLK), .rst(rst), .bus(bus27));
  ldpc_codeword_serializer #(.Z(81), .TOTAL_BLKS(NB), .OUT_W(W)) dut81 (.CLK(CLK), .rst(rst), .bus(bus81));

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [W:0]   exp_q [$];   // {last, data}
  logic [W-1:0] rx_log [NBEATS];
  int frame_beats = 0, last_len = 0, run_len = 0, max_run = 0, beats_seen = 0;
  bit rdy_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [FLAT-1:0] flatten(input cw_t cw);
    logic [FLAT-1:0] f;
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < Z; j++) f[k*Z + j] = cw[k][j];
    return f;
  endfunction

  function automatic cw_t rand_cw();
    cw_t cw;
    for (int k = 0; k < NB; k++) cw[k] = Z'({$urandom(), $urandom()});
    return cw;
  endfunction

  task automatic send_frame(input cw_t cw, input int budget);
    logic [FLAT-1:0] f;
    int n;
    f = flatten(cw);
    for (int i = 0; i < NBEATS; i++) exp_q.push_back({i == NBEATS - 1, f[i*W +: W]});
    bus.in_codeword = cw;
    bus.in_valid    = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.in_ready && n < budget);
    check("accept", bus.in_ready, 1);
    @(posedge CLK);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      @(posedge CLK);
      #1 n++;
    end
    check(name, bus.busy, 0);
  endtask

  // Sink readiness: always 1, or a coin flip per cycle during the stall test.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1 bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
  initial begin
    logic       stall_q;
    logic [W:0] stall_v, e;
    stall_q = 1'b0;
    stall_v = '0;
    forever begin
      @(negedge CLK);
      if (rst) begin
        stall_q = 1'b0; frame_beats = 0; run_len = 0;
      end else if (!bus.out_valid) begin
        check("idle_out", {bus.out_last, bus.out_data}, 0);
        stall_q = 1'b0; run_len = 0;
      end else begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (stall_q) check("stall_hold", {bus.out_last, bus.out_data}, stall_v);
        check("in_ready_stream", bus.in_ready, bus.out_ready && bus.out_last);
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {bus.out_last, bus.out_data}, 9'h1ff ^ {bus.out_last, bus.out_data});
          end else begin
            e = exp_q.pop_front();
            check($sformatf("beat%0d", frame_beats), {bus.out_last, bus.out_data}, e);
          end
          if (frame_beats < NBEATS) rx_log[frame_beats] = bus.out_data;
          frame_beats++;
          beats_seen++;
          if (bus.out_last) begin
            last_len = frame_beats; frame_beats = 0;
          end
          stall_q = 1'b0;
        end else begin
          stall_q = 1'b1;
          stall_v = {bus.out_last, bus.out_data};
        end
      end
    end
  end

  initial begin
    cw_t   cw;
    cw27_t c27;
    cw81_t c81;
    logic [7:0] kb;
    int base, n;

    bus.in_valid = 1'b0;
    bus.in_codeword = '{default: '0};
    bus27.in_valid = 1'b0; bus27.out_ready = 1'b1; bus27.in_codeword = '{default: '0};
    bus81.in_valid = 1'b0; bus81.out_ready = 1'b1; bus81.in_codeword = '{default: '0};
    rst = 1'b1;
    #2;
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last",  bus.out_last,  0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_busy",      bus.busy,      0);
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    #1 check("in_ready_after_rst", bus.in_ready, 1);

    // Single frame, block k filled with byte k replicated.
    for (int k = 0; k < NB; k++) begin
      kb = 8'(k);
      for (int j = 0; j < Z; j++) cw[k][j] = kb[j % 8];
    end
    send_frame(cw, 10);
    check("latency_valid", bus.out_valid, 1);
    check("latency_beat0", bus.out_data, 8'h00);
    check("busy_streaming", bus.in_ready, 0);
    wait_idle(400, "single_done");
    check("single_len", last_len, 162);
    check("single_beat6", rx_log[6], 8'h40);
    check("single_beat161", rx_log[161], 8'h5c);

    // Back-to-back frames with in_valid held high.
    max_run = 0;
    send_frame(rand_cw(), 10);
    send_frame(rand_cw(), 400);
    wait_idle(400, "b2b_done");
    check("b2b_run", max_run, 324);
    check("b2b_len", last_len, 162);

    // Random backpressure.
    rdy_rand = 1'b1;
    send_frame(rand_cw(), 10);
    wait_idle(2000, "bp_done");
    rdy_rand = 1'b0;
    check("bp_len", last_len, 162);

    // Asynchronous reset at beat 40.
    base = beats_seen;
    send_frame(rand_cw(), 10);
    n = 0;
    while (beats_seen - base < 40 && n < 300) begin
      @(posedge CLK);
      n++;
    end
    #3 rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_last",  bus.out_last,  0);
    check("mid_rst_data",  bus.out_data,  0);
    check("mid_rst_busy",  bus.busy,      0);
    check("mid_rst_ready", bus.in_ready,  0);
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    #1 check("ready_after_mid_rst", bus.in_ready, 1);
    send_frame(rand_cw(), 10);
    wait_idle(400, "post_rst_done");
    check("post_rst_len", last_len, 162);

    // in_codeword churn with in_valid high while in_ready is low.
    send_frame(rand_cw(), 10);
    bus.in_valid = 1'b1;
    repeat (100) begin
      @(posedge CLK);
      #1 bus.in_codeword = rand_cw();
    end
    bus.in_valid = 1'b0;
    wait_idle(400, "ignore_done");
    repeat (5) @(posedge CLK);
    #1 check("ignore_no_capture", bus.busy, 0);
    check("ignore_queue_empty", exp_q.size(), 0);

    // Z=27: 81 beats.
    for (int k = 0; k < NB; k++) c27[k] = 27'($urandom());
    bus27.in_codeword = c27;
    bus27.in_valid = 1'b1;
    @(posedge CLK);
    #1 bus27.in_valid = 1'b0;
    check("z27_beat0", bus27.out_data, c27[0][7:0]);
    n = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge CLK);
      if (bus27.out_valid) n++;
      if (bus27.out_last) break;
    end
    check("z27_last_pos", n, 81);
    repeat (3) @(posedge CLK);
    #1 check("z27_idle", bus27.busy, 0);

    // Z=81: 243 beats.
    for (int k = 0; k < NB; k++) c81[k] = 81'({$urandom(), $urandom(), $urandom()});
    bus81.in_codeword = c81;
    bus81.in_valid = 1'b1;
    @(posedge CLK);
    #1 bus81.in_valid = 1'b0;
    check("z81_beat0", bus81.out_data, c81[0][7:0]);
    n = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge CLK);
      if (bus81.out_valid) n++;
      if (bus81.out_last) break;
    end
    check("z81_last_pos", n, 243);
    repeat (3) @(posedge CLK);
    #1 check("z81_idle", bus81.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldpc_codeword_serializer.md
# ldpc_codeword_serializer

Downstream stage of the QC-LDPC encoder. It captures one complete parallel codeword (TOTAL_BLKS circulant blocks of Z bits) from the encoder with a valid/ready handshake. It then streams the codeword out as OUT_W-bit beats on a valid/ready/last interface toward the modulator/output FIFO. A capture register decouples the encoder from output backpressure, and back-to-back frames run with no bubble.

## Interface
- Z, 54, circulant size (27, 54 or 81)
- TOTAL_BLKS, 24, blocks per codeword (info + parity)
- OUT_W, 8, output beat width in bits; Z*TOTAL_BLKS must be a multiple of OUT_W, otherwise elaboration fails ($error)
- NUM_BEATS (localparam), Z*TOTAL_BLKS/OUT_W; beat counter width $clog2(NUM_BEATS)

- CLK  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_codeword  in  [Z-1:0] x [TOTAL_BLKS-1:0]  unpacked codeword from the encoder
- in_valid  in  1  in_codeword is valid
- in_ready  out  1  serializer can accept a codeword this cycle
- out_data  out  OUT_W  current beat
- out_valid  out  1  out_data is valid
- out_last  out  1  final beat of the frame
- out_ready  in  1  downstream accepts the beat
- busy  out  1  a frame is held or streaming

## Operation
- Flattening: flat[k*Z + j] = in_codeword[k][j]. Block 0 goes first, LSB first within each block. Beat i = flat[i*OUT_W +: OUT_W]. Beats may straddle block boundaries.
- Capture: on in_valid && in_ready, the whole codeword is registered into the frame buffer, the beat counter is cleared, and the FSM enters SEND.
- FSM states and transitions:
  - IDLE → SEND on accept.
  - In SEND, each out_valid && out_ready increments the beat counter.
  - On the accepted beat with counter == NUM_BEATS-1 (out_last): if in_valid is also high, the new frame is captured and the FSM stays in SEND with the counter at 0. Otherwise it goes to IDLE.
- in_ready = !rst && (state==IDLE || (out_valid && out_ready && out_last)). It is combinational and never depends on in_valid.
- out_valid = (state==SEND). out_last = out_valid && counter==NUM_BEATS-1. busy = (state==SEND).
- out_data is driven from the buffer indexed by the counter (registered mux or shift register; either is acceptable). It must be 0 whenever out_valid is 0.
- in_codeword is ignored when not accepted. Changing it while a frame streams has no effect.
- Backpressure: while out_valid && !out_ready, out_data, out_last and the counter hold.
- Reset: asynchronous assertion immediately forces IDLE, counter 0, buffer content don't-care, out_valid=0, out_last=0, out_data=0, busy=0, in_ready=0. In-flight frames are discarded with no partial last. in_ready rises in the first cycle after deassertion.

## Timing
- Latency: capture at edge t puts beat 0 on out_data with out_valid=1 immediately after edge t (visible cycle t+1).
- A frame occupies exactly NUM_BEATS cycles with out_ready held high. Throughput is one beat per cycle, with no bubble between consecutive frames.
- Simultaneous last-beat accept and new capture: beat NUM_BEATS-1 of frame A is followed in the very next cycle by beat 0 of frame B.
- No combinational path from in_valid to out_*. out_ready→in_ready is combinational (single gate level).
- Reset values of every output: in_ready 0 (during rst), out_valid 0, out_last 0, out_data 0, busy 0.

## Test plan
- Single frame, Z=54, TOTAL_BLKS=24, OUT_W=8, out_ready=1, in_codeword[k]=k (replicated) → 162 beats. Beat 0 = in_codeword[0][7:0]. Beat 6 = {in_codeword[1][1:0], in_codeword[0][53:48]}. out_last only on beat 161. in_ready=0 from capture until beat 161.
- Back-to-back: in_valid held high with frames A then B → B accepted on A's last beat. B beat 0 appears the cycle after A beat 161, with no idle cycle. A total of 324 consecutive valid beats.
- Backpressure: random out_ready (~50% low), random data → reassembled stream equals the flattened input bit-exactly. out_data/out_last are stable across every stall. Beat count is 162.
- Reset mid-frame: assert rst asynchronously (between edges) at beat 40 → out_valid/out_last/out_data drop to 0 immediately. After release, a new frame streams from beat 0 with correct data and no remnant of the old frame.
- Parameter sweep: Z=27 (81 beats) and Z=81 (243 beats) with OUT_W=8 → beat counts and out_last position correct. Z=54, OUT_W=7 → elaboration error (1296 not divisible by 7).
- Input ignore: toggle in_codeword while streaming with in_valid=1 and in_ready=0 → output stream is unaffected and no extra frame is captured.
